// File: rtl/exe_wb_stage_pkg.sv
// Shared widths and operand-source encoding for the EXE->WB writeback/bypass slice.
package exe_wb_stage_pkg;

    localparam int DSIZE = 16;
    localparam int ASIZE = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_EXE = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/exe_wb_stage_fwd_mux.sv
// Operand bypass select: the younger EXE result wins over WB, which wins over the regfile.
module fwd_mux #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             ex_wr,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic [DSIZE-1:0] ex_result,
    input  logic             wb_valid,
    input  logic [ASIZE-1:0] wb_waddr,
    input  logic [DSIZE-1:0] wb_wdata,
    input  logic [ASIZE-1:0] raddr,
    input  logic [DSIZE-1:0] rf_rdata,
    output logic [DSIZE-1:0] rdata,
    output logic [1:0]       sel
);
    import exe_wb_stage_pkg::*;

    fwd_sel_e sel_e;

    // WB stays a valid source after its write commits, until the regfile read catches up
    always_comb begin
        sel_e = FWD_RF;
        rdata = rf_rdata;
        if (ex_wr && (ex_waddr == raddr)) begin
            sel_e = FWD_EXE;
            rdata = ex_result;
        end else if (wb_valid && (wb_waddr == raddr)) begin
            sel_e = FWD_WB;
            rdata = wb_wdata;
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/exe_wb_stage.sv
// EXE->WB pipeline register with single-shot regfile write, operand bypass and retire counter.
module exe_wb_stage #(
    parameter int DSIZE = exe_wb_stage_pkg::DSIZE,
    parameter int ASIZE = exe_wb_stage_pkg::ASIZE,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_wen,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic [DSIZE-1:0] ex_result,
    input  logic             stall,
    input  logic             flush,
    input  logic [ASIZE-1:0] id_raddr1,
    input  logic [ASIZE-1:0] id_raddr2,
    input  logic [DSIZE-1:0] rf_rdata1,
    input  logic [DSIZE-1:0] rf_rdata2,
    output logic             wb_wen,
    output logic [ASIZE-1:0] wb_waddr,
    output logic [DSIZE-1:0] wb_wdata,
    output logic             wb_valid,
    output logic [DSIZE-1:0] fwd_rdata1,
    output logic [DSIZE-1:0] fwd_rdata2,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNTW-1:0]  retire_cnt
);
    logic             wb_valid_q, wb_valid_d;
    logic [ASIZE-1:0] wb_waddr_q, wb_waddr_d;
    logic [DSIZE-1:0] wb_wdata_q, wb_wdata_d;
    logic             done_q, done_d;
    logic [CNTW-1:0]  retire_cnt_q, retire_cnt_d;
    logic             ex_wr;

    assign ex_wr  = ex_valid & ex_wen;
    // done marks an instruction already written while stalled, so it writes only once
    assign wb_wen = wb_valid_q & ~done_q;

    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_waddr_d   = wb_waddr_q;
        wb_wdata_d   = wb_wdata_q;
        done_d       = done_q;
        retire_cnt_d = retire_cnt_q + CNTW'(wb_wen);
        if (flush) begin
            wb_valid_d = 1'b0;
            done_d     = 1'b0;
        end else if (stall) begin
            done_d = wb_wen | done_q;
        end else begin
            wb_valid_d = ex_wr;
            wb_waddr_d = ex_waddr;
            wb_wdata_d = ex_result;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q   <= 1'b0;
            wb_waddr_q   <= '0;
            wb_wdata_q   <= '0;
            done_q       <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_waddr_q   <= wb_waddr_d;
            wb_wdata_q   <= wb_wdata_d;
            done_q       <= done_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_waddr   = wb_waddr_q;
    assign wb_wdata   = wb_wdata_q;
    assign retire_cnt = retire_cnt_q;

    fwd_mux #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_fwd1 (
        .ex_wr    (ex_wr),
        .ex_waddr (ex_waddr),
        .ex_result(ex_result),
        .wb_valid (wb_valid_q),
        .wb_waddr (wb_waddr_q),
        .wb_wdata (wb_wdata_q),
        .raddr    (id_raddr1),
        .rf_rdata (rf_rdata1),
        .rdata    (fwd_rdata1),
        .sel      (fwd_sel1)
    );

    fwd_mux #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_fwd2 (
        .ex_wr    (ex_wr),
        .ex_waddr (ex_waddr),
        .ex_result(ex_result),
        .wb_valid (wb_valid_q),
        .wb_waddr (wb_waddr_q),
        .wb_wdata (wb_wdata_q),
        .raddr    (id_raddr2),
        .rf_rdata (rf_rdata2),
        .rdata    (fwd_rdata2),
        .sel      (fwd_sel2)
    );

endmodule
